// File: rtl/obj_renderer.sv
// Object renderer: latches ball/racket descriptors once per frame, renders them into
// a two-stage pixel pipeline and reports per-frame ball/racket collisions.
module obj_renderer #(
    parameter int          NUM_OBJ   = 4,
    parameter int          BALL_SIZE = 16,
    parameter int          RACK_W    = 8,
    parameter int          RACK_H    = 64,
    parameter logic [23:0] BG_COLOR  = 24'h000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_start_strobe,
    input  logic                      line_start,
    input  logic                      pix_valid,
    input  logic [NUM_OBJ-1:0][11:0]  obj_x,
    input  logic [NUM_OBJ-1:0][11:0]  obj_y,
    input  logic [NUM_OBJ-1:0]        obj_en,
    input  logic [NUM_OBJ-1:0][23:0]  obj_color,
    output logic                      pix_out_valid,
    output logic [23:0]               pix_rgb,
    output logic [3:0]                collision,
    output logic                      collision_strobe
);

    // Pixel stream: pix_valid -> v1 -> pix_out_valid. There is no backpressure;
    // every valid beat is accepted and emitted exactly two clocks later.

    function automatic logic [12:0] obj_w(input int i);
        return (i < 2) ? 13'(BALL_SIZE) : 13'(RACK_W);
    endfunction

    function automatic logic [12:0] obj_h(input int i);
        return (i < 2) ? 13'(BALL_SIZE) : 13'(RACK_H);
    endfunction

    logic [11:0]               x_cnt;
    logic [11:0]               y_cnt;
    logic [NUM_OBJ-1:0][11:0]  sh_x;
    logic [NUM_OBJ-1:0][11:0]  sh_y;
    logic [NUM_OBJ-1:0]        sh_en;
    logic [NUM_OBJ-1:0][23:0]  sh_color;
    logic [NUM_OBJ-1:0]        hit_c;
    logic [NUM_OBJ-1:0]        hit1;
    logic                      v1;
    logic [23:0]               color_c;
    logic [3:0]                pair_c;
    logic [3:0]                acc;

    // Shadow set: only the frame strobe updates it, so a frame never tears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_en    <= '0;
            sh_color <= '0;
        end else if (frame_start_strobe) begin
            sh_x     <= obj_x;
            sh_y     <= obj_y;
            sh_en    <= obj_en;
            sh_color <= obj_color;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt <= '0;
            y_cnt <= 12'hFFF;
        end else if (frame_start_strobe) begin
            x_cnt <= '0;
            y_cnt <= line_start ? 12'h000 : 12'hFFF;
        end else if (line_start) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 12'd1;
        end else if (pix_valid && (x_cnt != 12'hFFF)) begin
            x_cnt <= x_cnt + 12'd1;
        end
    end

    // Bounds are compared at 13 bits so objects near 4095 never wrap to row/column 0.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit_c[i] = sh_en[i]
                    && ({1'b0, x_cnt} >= {1'b0, sh_x[i]})
                    && ({1'b0, x_cnt} <  ({1'b0, sh_x[i]} + obj_w(i)))
                    && ({1'b0, y_cnt} >= {1'b0, sh_y[i]})
                    && ({1'b0, y_cnt} <  ({1'b0, sh_y[i]} + obj_h(i)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit1 <= '0;
            v1   <= 1'b0;
        end else begin
            hit1 <= pix_valid ? hit_c : '0;
            v1   <= pix_valid;
        end
    end

    // Lowest index wins: balls over rackets, ball0 over ball1.
    always_comb begin
        color_c = BG_COLOR;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit1[i]) begin
                color_c = sh_color[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_out_valid <= 1'b0;
            pix_rgb       <= BG_COLOR;
        end else begin
            pix_out_valid <= v1;
            pix_rgb       <= v1 ? color_c : BG_COLOR;
        end
    end

    always_comb begin
        pair_c = '0;
        if (v1) begin
            pair_c = {hit1[1] & hit1[3], hit1[1] & hit1[2],
                      hit1[0] & hit1[3], hit1[0] & hit1[2]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc              <= '0;
            collision        <= '0;
            collision_strobe <= 1'b0;
        end else if (frame_start_strobe) begin
            collision        <= acc | pair_c;
            acc              <= '0;
            collision_strobe <= 1'b1;
        end else begin
            acc              <= acc | pair_c;
            collision_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_obj_renderer.sv
// Bench for obj_renderer: drives frames/lines, predicts every output pixel (with its
// arrival cycle) and the per-frame collision flags from a geometric object model.
module tb_obj_renderer;

    localparam logic [23:0] BG = 24'h000000;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             frame_start_strobe = 1'b0;
    logic             line_start = 1'b0;
    logic             pix_valid = 1'b0;
    logic [3:0][11:0] obj_x = '0;
    logic [3:0][11:0] obj_y = '0;
    logic [3:0]       obj_en = '0;
    logic [3:0][23:0] obj_color = '0;
    logic             pix_out_valid;
    logic [23:0]      pix_rgb;
    logic [3:0]       collision;
    logic             collision_strobe;

    obj_renderer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .frame_start_strobe (frame_start_strobe),
        .line_start         (line_start),
        .pix_valid          (pix_valid),
        .obj_x              (obj_x),
        .obj_y              (obj_y),
        .obj_en             (obj_en),
        .obj_color          (obj_color),
        .pix_out_valid      (pix_out_valid),
        .pix_rgb            (pix_rgb),
        .collision          (collision),
        .collision_strobe   (collision_strobe)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          idle_bad = 0;
    logic [55:0] exp_q[$];
    logic [55:0] got_q[$];

    // Reference model state: the frame's latched objects, current row, collision flags.
    int          m_sx[4];
    int          m_sy[4];
    bit          m_sen[4];
    logic [23:0] m_scol[4];
    int          m_y = 4095;
    logic [3:0]  m_acc = '0;
    logic [3:0]  m_coll = '0;

    function automatic bit ref_hit(int i, int x, int y);
        int w, h;
        w = (i < 2) ? 16 : 8;
        h = (i < 2) ? 16 : 64;
        return m_sen[i] && (x >= m_sx[i]) && (x < m_sx[i] + w)
                        && (y >= m_sy[i]) && (y < m_sy[i] + h);
    endfunction

    function automatic logic [23:0] ref_color(int x, int y);
        for (int i = 0; i < 4; i++) begin
            if (ref_hit(i, x, y)) return m_scol[i];
        end
        return BG;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (pix_out_valid === 1'b1) got_q.push_back({32'(cyc), pix_rgb});
        else if (pix_rgb !== BG) idle_bad++;
    endtask

    task automatic frame_strobe();
        frame_start_strobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_sx[i]   = int'(obj_x[i]);
            m_sy[i]   = int'(obj_y[i]);
            m_sen[i]  = obj_en[i];
            m_scol[i] = obj_color[i];
        end
        m_coll = m_acc;
        m_acc  = '0;
        m_y    = 4095;
        step();
        frame_start_strobe = 1'b0;
    endtask

    task automatic drive_line(input int npix);
        line_start = 1'b1;
        m_y = (m_y + 1) % 4096;
        step();
        line_start = 1'b0;
        for (int i = 0; i < npix; i++) begin
            int x;
            x = (i > 4095) ? 4095 : i;
            pix_valid = 1'b1;
            exp_q.push_back({32'(cyc + 2), ref_color(x, m_y)});
            m_acc[0] = m_acc[0] | (ref_hit(0, x, m_y) & ref_hit(2, x, m_y));
            m_acc[1] = m_acc[1] | (ref_hit(0, x, m_y) & ref_hit(3, x, m_y));
            m_acc[2] = m_acc[2] | (ref_hit(1, x, m_y) & ref_hit(2, x, m_y));
            m_acc[3] = m_acc[3] | (ref_hit(1, x, m_y) & ref_hit(3, x, m_y));
            step();
        end
        pix_valid = 1'b0;
        step();
        step();
    endtask

    task automatic skip_lines(input int n);
        line_start = 1'b1;
        repeat (n) step();
        line_start = 1'b0;
        m_y = (m_y + n) % 4096;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if (pix_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset pix_out_valid: got %b, expected 0", pix_out_valid);
        end
        checks++;
        if (pix_rgb !== BG) begin
            errors++; $display("FAIL reset pix_rgb: got %06h, expected %06h", pix_rgb, BG);
        end
        checks++;
        if (collision !== 4'b0000) begin
            errors++; $display("FAIL reset collision: got %b, expected 0000", collision);
        end
        checks++;
        if (collision_strobe !== 1'b0) begin
            errors++; $display("FAIL reset collision_strobe: got %b, expected 0", collision_strobe);
        end
        reset_n = 1'b1;
        step();
        got_q.delete(); idle_bad = 0;
    endtask

    task automatic test_blank_line();
        obj_en = '0;
        frame_strobe();
        checks++;
        if (collision_strobe !== 1'b1 || collision !== 4'b0000) begin
            errors++; $display("FAIL blank strobe: got strobe=%b coll=%b, expected 1/0000", collision_strobe, collision);
        end
        drive_line(640);
        checks++;
        if (got_q.size() != 640) begin
            errors++; $display("FAIL blank beats: got %0d, expected 640", got_q.size());
        end
        foreach (exp_q[k]) begin
            if (k >= got_q.size()) break;
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL blank pixel %0d: got cyc %0d rgb %06h, expected cyc %0d rgb %06h", k, got_q[k][55:24], got_q[k][23:0], exp_q[k][55:24], exp_q[k][23:0]);
                break;
            end
        end
        checks++;
        if (idle_bad != 0) begin
            errors++; $display("FAIL blank idle_rgb: got %0d non-background idle beats, expected 0", idle_bad);
        end
        exp_q.delete(); got_q.delete(); idle_bad = 0;
    endtask

    task automatic test_ball();
        int n_red;
        obj_en = 4'b0001;
        obj_x[0] = 12'd100; obj_y[0] = 12'd50; obj_color[0] = 24'hFF0000;
        frame_strobe();
        for (int l = 0; l < 80; l++) drive_line(130);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL ball beats: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k >= got_q.size()) break;
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL ball pixel %0d: got cyc %0d rgb %06h, expected cyc %0d rgb %06h", k, got_q[k][55:24], got_q[k][23:0], exp_q[k][55:24], exp_q[k][23:0]);
                break;
            end
        end
        n_red = 0;
        foreach (got_q[k]) if (got_q[k][23:0] == 24'hFF0000) n_red++;
        checks++;
        if (n_red != 256) begin
            errors++; $display("FAIL ball area: got %0d red pixels, expected 256", n_red);
        end
        exp_q.delete(); got_q.delete(); idle_bad = 0;
    endtask

    task automatic test_overlap();
        int n_ball;
        obj_en = 4'b0101;
        obj_x[0] = 12'd0; obj_y[0] = 12'd16; obj_color[0] = 24'($urandom_range(24'h800000, 24'hFFFFFF));
        obj_x[2] = 12'd0; obj_y[2] = 12'd0;  obj_color[2] = 24'($urandom_range(1, 24'h7FFFFF));
        frame_strobe();
        for (int l = 0; l < 40; l++) drive_line(24);
        n_ball = 0;
        foreach (got_q[k]) if (got_q[k][23:0] == obj_color[0]) n_ball++;
        checks++;
        if (n_ball != 256) begin
            errors++; $display("FAIL overlap ball_on_top: got %0d ball pixels, expected 256", n_ball);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL overlap beats: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k >= got_q.size()) break;
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL overlap pixel %0d: got cyc %0d rgb %06h, expected cyc %0d rgb %06h", k, got_q[k][55:24], got_q[k][23:0], exp_q[k][55:24], exp_q[k][23:0]);
                break;
            end
        end
        exp_q.delete(); got_q.delete(); idle_bad = 0;
        obj_x[2] = 12'd200;
        frame_strobe();
        checks++;
        if (collision !== 4'b0001 || collision !== m_coll || collision_strobe !== 1'b1) begin
            errors++; $display("FAIL overlap collision: got coll=%b strobe=%b, expected coll=0001 (model %b) strobe=1", collision, collision_strobe, m_coll);
        end
        step();
        checks++;
        if (collision_strobe !== 1'b0 || collision !== 4'b0001) begin
            errors++; $display("FAIL overlap strobe_width: got strobe=%b coll=%b, expected 0/0001", collision_strobe, collision);
        end
        for (int l = 0; l < 40; l++) drive_line(24);
        frame_strobe();
        checks++;
        if (collision !== 4'b0000 || collision_strobe !== 1'b1) begin
            errors++; $display("FAIL overlap cleared: got coll=%b strobe=%b, expected 0000/1", collision, collision_strobe);
        end
        exp_q.delete(); got_q.delete(); idle_bad = 0;
    endtask

    task automatic test_mid_frame_change();
        obj_en = 4'b0001;
        obj_x[0] = 12'd100; obj_y[0] = 12'd4; obj_color[0] = 24'($urandom_range(1, 24'hFFFFFF));
        frame_strobe();
        for (int l = 0; l < 10; l++) drive_line(320);
        obj_x[0] = 12'd300;
        for (int l = 10; l < 24; l++) drive_line(320);
        frame_strobe();
        for (int l = 0; l < 24; l++) drive_line(320);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midframe beats: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k >= got_q.size()) break;
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL midframe pixel %0d: got cyc %0d rgb %06h, expected cyc %0d rgb %06h", k, got_q[k][55:24], got_q[k][23:0], exp_q[k][55:24], exp_q[k][23:0]);
                break;
            end
        end
        exp_q.delete(); got_q.delete(); idle_bad = 0;
    endtask

    task automatic test_no_wrap();
        int n_hit;
        obj_en = 4'b1000;
        obj_x[3] = 12'd4090; obj_y[3] = 12'd4060; obj_color[3] = 24'h00FF00;
        frame_strobe();
        for (int l = 0; l < 12; l++) drive_line(6);
        skip_lines(4057 - 11);
        for (int l = 0; l < 4; l++) drive_line(4100);
        n_hit = 0;
        foreach (got_q[k]) if (got_q[k][23:0] == 24'h00FF00) n_hit++;
        checks++;
        if (n_hit != 20) begin
            errors++; $display("FAIL nowrap area: got %0d racket pixels, expected 20", n_hit);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL nowrap beats: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k >= got_q.size()) break;
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL nowrap pixel %0d: got cyc %0d rgb %06h, expected cyc %0d rgb %06h", k, got_q[k][55:24], got_q[k][23:0], exp_q[k][55:24], exp_q[k][23:0]);
                break;
            end
        end
        exp_q.delete(); got_q.delete(); idle_bad = 0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 4; i++) begin
                obj_x[i]     = 12'($urandom_range(0, 90));
                obj_y[i]     = 12'($urandom_range(0, 30));
                obj_en[i]    = ($urandom_range(0, 3) != 0);
                obj_color[i] = 24'($urandom_range(1, 24'hFFFFFF));
            end
            frame_strobe();
            checks++;
            if (collision !== m_coll || collision_strobe !== 1'b1) begin
                errors++; $display("FAIL random collision frame %0d: got coll=%b strobe=%b, expected coll=%b strobe=1", f, collision, collision_strobe, m_coll);
            end
            if (f == 3) break;
            for (int l = 0; l < 40; l++) drive_line(100);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL random beats frame %0d: got %0d, expected %0d", f, got_q.size(), exp_q.size());
            end
            foreach (exp_q[k]) begin
                if (k >= got_q.size()) break;
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++; $display("FAIL random pixel f%0d/%0d: got cyc %0d rgb %06h, expected cyc %0d rgb %06h", f, k, got_q[k][55:24], got_q[k][23:0], exp_q[k][55:24], exp_q[k][23:0]);
                    break;
                end
            end
            checks++;
            if (idle_bad != 0) begin
                errors++; $display("FAIL random idle_rgb: got %0d non-background idle beats, expected 0", idle_bad);
            end
            exp_q.delete(); got_q.delete(); idle_bad = 0;
        end
    endtask

    task automatic test_reset_mid_frame();
        obj_en = 4'b0101;
        obj_x[0] = 12'd0; obj_y[0] = 12'd16;
        obj_x[2] = 12'd0; obj_y[2] = 12'd0;
        frame_strobe();
        for (int l = 0; l < 20; l++) drive_line(10);
        frame_strobe();
        checks++;
        if (collision !== 4'b0001 || collision !== m_coll) begin
            errors++; $display("FAIL rstmid pre_collision: got %b, expected 0001 (model %b)", collision, m_coll);
        end
        line_start = 1'b1; step(); line_start = 1'b0;
        pix_valid = 1'b1;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        checks++;
        if (pix_out_valid !== 1'b0 || pix_rgb !== BG) begin
            errors++; $display("FAIL rstmid async_flush: got valid=%b rgb=%06h, expected 0/%06h", pix_out_valid, pix_rgb, BG);
        end
        checks++;
        if (collision !== 4'b0000) begin
            errors++; $display("FAIL rstmid collision: got %b, expected 0000", collision);
        end
        got_q.delete(); idle_bad = 0;
        repeat (3) step();
        pix_valid = 1'b0;
        checks++;
        if (got_q.size() != 0 || idle_bad != 0) begin
            errors++; $display("FAIL rstmid quiet: got %0d beats and %0d bad idle beats, expected 0/0", got_q.size(), idle_bad);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) m_sen[i] = 1'b0;
        m_acc = '0; m_y = 4095;
        exp_q.delete(); got_q.delete(); idle_bad = 0;
        step();
        obj_en = 4'b0001;
        obj_x[0] = 12'd20; obj_y[0] = 12'd2; obj_color[0] = 24'($urandom_range(1, 24'hFFFFFF));
        frame_strobe();
        checks++;
        if (collision !== 4'b0000 || collision_strobe !== 1'b1) begin
            errors++; $display("FAIL rstmid post_strobe: got coll=%b strobe=%b, expected 0000/1", collision, collision_strobe);
        end
        for (int l = 0; l < 20; l++) drive_line(40);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rstmid beats: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k >= got_q.size()) break;
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL rstmid pixel %0d: got cyc %0d rgb %06h, expected cyc %0d rgb %06h", k, got_q[k][55:24], got_q[k][23:0], exp_q[k][55:24], exp_q[k][23:0]);
                break;
            end
        end
        exp_q.delete(); got_q.delete(); idle_bad = 0;
    endtask

    initial begin
        test_reset();
        test_blank_line();
        test_ball();
        test_overlap();
        test_mid_frame_change();
        test_no_wrap();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
